// File: rtl/ecc_pkg.sv
// ============================================================================
// Module  : ecc_pkg
// Purpose : Shared SECDED Hamming helpers used by both the encoder and the
//           decoder side of the project: check-bit count, power-of-two test,
//           data-bit <-> code-word position mapping and per-parity-bit
//           coverage masks.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_pkg;

  // Smallest m with 2**m >= m + k + 1.
  function automatic int calculate_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

  function automatic bit is_power_of_2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data bit number carried at code-word position pos (pos must not be a
  // power of two): the count of data positions below pos.
  function automatic int data_index(input int pos);
    int cnt;
    cnt = 0;
    for (int p = 1; p < pos; p++) begin
      if (!is_power_of_2(p)) cnt++;
    end
    return cnt;
  endfunction

  // Code-word position that carries data bit idx (inverse of data_index).
  function automatic int data_pos(input int idx);
    int pos;
    int seen;
    pos  = 0;
    seen = -1;
    while (seen < idx) begin
      pos++;
      if (!is_power_of_2(pos)) seen++;
    end
    return pos;
  endfunction

  // Bit p set when data position p (1..n) is covered by parity bit 2**j.
  function automatic logic [63:0] parity_mask(input int n, input int j);
    logic [63:0] mk;
    mk = '0;
    for (int p = 1; p <= n; p++) begin
      if (!is_power_of_2(p) && (((p >> j) & 1) == 1)) mk = mk | (64'd1 << p);
    end
    return mk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_enc_core.sv
// ============================================================================
// Module  : ecc_enc_core
// Purpose : Purely combinational SECDED Hamming encoder. Produces the code
//           word cw[n:0] in natural order (overall parity at bit 0).
// Ports   : data_i  [K-1:0]  information bits
//           cw_o    [N:0]    code word, index 0 = overall parity
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_enc_core
  import ecc_pkg::*;
#(
  parameter  int K = 32,
  localparam int M = calculate_m(K),
  localparam int N = M + K
) (
  input  logic [K-1:0] data_i,
  output logic [N:0]   cw_o
);

  logic [N:1] w_data_pos;  // data bits in place, zeros at parity positions
  logic [N:1] w_body;      // data plus Hamming parity bits

  for (genvar p = 1; p <= N; p++) begin : g_pos
    if (is_power_of_2(p)) begin : g_par
      // Parity position 2**j covers every data position with bit j set.
      localparam logic [63:0] PMASK = parity_mask(N, $clog2(p));
      assign w_data_pos[p] = 1'b0;
      assign w_body[p]     = ^(w_data_pos & PMASK[N:1]);
    end else begin : g_dat
      assign w_data_pos[p] = data_i[data_index(p)];
      assign w_body[p]     = data_i[data_index(p)];
    end
  end

  // Overall parity makes the complete word even.
  assign cw_o = {w_body, ^w_body};

endmodule

`default_nettype wire

// File: rtl/ecc_enc_stream.sv
// ============================================================================
// Module  : ecc_enc_stream
// Purpose : Streaming SECDED encoder with valid/ready handshakes, 1 or 2
//           pipeline stages, selectable overall-parity placement and
//           per-word fault injection.
// Ports   : clk_i, rst_i (sync, active high)
//           in_valid_i / in_ready_o / data_i[K-1:0] / inj_mask_i[N:0]
//           out_valid_o / out_ready_i / cw_o[N:0] / inj_o
//           word_cnt_o[31:0] completed output transfers (wrapping)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_enc_stream
  import ecc_pkg::*;
#(
  parameter  int K       = 32,
  parameter  int LATENCY = 1,
  parameter  int P0_LSB  = 1,
  localparam int M       = calculate_m(K),
  localparam int N       = M + K
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [K-1:0] data_i,
  input  logic [N:0]   inj_mask_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N:0]   cw_o,
  output logic         inj_o,
  output logic [31:0]  word_cnt_o
);

  logic [K-1:0] w_enc_data;
  logic [N:0]   w_enc_mask;
  logic         w_up_valid;   // a word enters the output stage this cycle
  logic [N:0]   w_cw_raw;
  logic [N:0]   w_cw_ord;
  logic [N:0]   w_cw_fin;
  logic         w_out_drain;
  logic         w_out_space;

  logic         out_full_q, out_full_d;
  logic [N:0]   cw_q, cw_d;
  logic         inj_q, inj_d;
  logic [31:0]  word_cnt_q, word_cnt_d;

  assign w_out_drain = out_full_q & out_ready_i;
  assign w_out_space = ~out_full_q | w_out_drain;

  if (LATENCY == 1) begin : g_lat1
    assign in_ready_o = ~rst_i & w_out_space;
    assign w_up_valid = in_valid_i & in_ready_o;
    assign w_enc_data = data_i;
    assign w_enc_mask = inj_mask_i;
  end else if (LATENCY == 2) begin : g_lat2
    logic         in_full_q, in_full_d;
    logic [K-1:0] in_data_q, in_data_d;
    logic [N:0]   in_mask_q, in_mask_d;
    logic         w_in_drain;
    logic         w_in_load;

    assign w_in_drain = in_full_q & w_out_space;
    assign in_ready_o = ~rst_i & (~in_full_q | w_in_drain);
    assign w_in_load  = in_valid_i & in_ready_o;

    always_comb begin
      in_full_d = in_full_q;
      in_data_d = in_data_q;
      in_mask_d = in_mask_q;
      if (w_in_load) begin
        in_full_d = 1'b1;
        in_data_d = data_i;
        in_mask_d = inj_mask_i;
      end else if (w_in_drain) begin
        in_full_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        in_full_q <= 1'b0;
        in_data_q <= '0;
        in_mask_q <= '0;
      end else begin
        in_full_q <= in_full_d;
        in_data_q <= in_data_d;
        in_mask_q <= in_mask_d;
      end
    end

    // Encoding is computed from the input stage register.
    assign w_up_valid = w_in_drain;
    assign w_enc_data = in_data_q;
    assign w_enc_mask = in_mask_q;
  end else begin : g_lat_bad
    $error("ecc_enc_stream: LATENCY must be 1 or 2");
    assign in_ready_o = 1'b0;
    assign w_up_valid = 1'b0;
    assign w_enc_data = '0;
    assign w_enc_mask = '0;
  end

  ecc_enc_core #(
    .K (K)
  ) u_core (
    .data_i (w_enc_data),
    .cw_o   (w_cw_raw)
  );

  if (P0_LSB != 0) begin : g_p0_lsb
    assign w_cw_ord = w_cw_raw;
  end else begin : g_p0_msb
    assign w_cw_ord = {w_cw_raw[0], w_cw_raw[N:1]};
  end

  // Injection mask is in output bit order, so it applies after placement.
  assign w_cw_fin = w_cw_ord ^ w_enc_mask;

  always_comb begin
    out_full_d = out_full_q;
    cw_d       = cw_q;
    inj_d      = inj_q;
    word_cnt_d = word_cnt_q;
    // w_up_valid already implies the stage is empty or draining.
    if (w_up_valid) begin
      out_full_d = 1'b1;
      cw_d       = w_cw_fin;
      inj_d      = |w_enc_mask;
    end else if (w_out_drain) begin
      out_full_d = 1'b0;
    end
    if (w_out_drain) word_cnt_d = word_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_full_q <= 1'b0;
      cw_q       <= '0;
      inj_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      out_full_q <= out_full_d;
      cw_q       <= cw_d;
      inj_q      <= inj_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign out_valid_o = out_full_q;
  assign cw_o        = cw_q;
  assign inj_o       = inj_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_enc_stream.sv
// ============================================================================
// Module  : tb_ecc_enc_stream
// Purpose : Scoreboard bench for ecc_enc_stream. Two instances run side by
//           side: dut_a (LATENCY=1, P0_LSB=1) and dut_b (LATENCY=2, P0_LSB=0),
//           each with its own input/output handshake channel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecc_enc_stream;

  typedef struct {
    logic [31:0] data;
    logic [38:0] mask;
    bit          fixed;
    logic [38:0] fcw;
  } in_t;

  typedef struct {
    logic [38:0] cw;
    logic        inj;
    logic [31:0] data;
    logic [38:0] mask;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] data      [2];
  logic [38:0] mask      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [38:0] cw        [2];
  logic        inj       [2];
  logic [31:0] wcnt      [2];

  in_t  pend0[$], pend1[$];
  exp_t sb0[$],   sb1[$];

  int          n_checks;
  int          n_fail;
  int          acc_cnt   [2];
  int          n_xfer    [2];
  logic [31:0] cnt_model [2];
  bit          held      [2];
  logic [38:0] held_cw   [2];
  logic        held_inj  [2];
  int          vprob     [2];
  int          rprob     [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ecc_enc_stream #(.K(32), .LATENCY(1), .P0_LSB(1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .data_i(data[0]), .inj_mask_i(mask[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .cw_o(cw[0]), .inj_o(inj[0]), .word_cnt_o(wcnt[0])
  );

  ecc_enc_stream #(.K(32), .LATENCY(2), .P0_LSB(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .data_i(data[1]), .inj_mask_i(mask[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .cw_o(cw[1]), .inj_o(inj[1]), .word_cnt_o(wcnt[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [38:0] model(input logic [31:0] d, input logic [38:0] m,
                                        input bit p0lsb);
    bit          c[39];
    int          di;
    bit          p;
    logic [38:0] r;
    di = 0;
    for (int pos = 0; pos <= 38; pos++) c[pos] = 1'b0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[di];
        di++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 38; pos++) if (((pos >> j) & 1) == 1) p = p ^ c[pos];
      c[1 << j] = p;
    end
    p = 1'b0;
    for (int pos = 1; pos <= 38; pos++) p = p ^ c[pos];
    c[0] = p;
    for (int i = 0; i <= 38; i++) begin
      if (p0lsb) r[i] = c[i];
      else if (i == 0) r[38] = c[0];
      else r[i-1] = c[i];
    end
    return r ^ m;
  endfunction

  // Behavioural SECDED decoder for round-trip checking.
  task automatic decode(input logic [38:0] w, input bit p0lsb,
                        output logic [31:0] q, output bit sb, output bit db);
    bit c[39];
    int syn;
    bit par;
    int di;
    syn = 0;
    par = 1'b0;
    for (int i = 0; i <= 38; i++) begin
      if (p0lsb) c[i] = w[i];
      else if (i == 0) c[0] = w[38];
      else c[i] = w[i-1];
    end
    for (int i = 0; i <= 38; i++) begin
      if (c[i]) begin
        par = ~par;
        syn = syn ^ i;
      end
    end
    sb = par;
    db = !par && (syn != 0);
    if (par && syn <= 38) c[syn] = ~c[syn];
    di = 0;
    q  = '0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        q[di] = c[pos];
        di++;
      end
    end
  endtask

  // ---------------- queue helpers ----------------
  function automatic int pend_size(input int d);
    return (d == 0) ? pend0.size() : pend1.size();
  endfunction
  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction
  function automatic in_t pend_head(input int d);
    return (d == 0) ? pend0[0] : pend1[0];
  endfunction
  function automatic in_t pend_pop(input int d);
    if (d == 0) return pend0.pop_front();
    return pend1.pop_front();
  endfunction
  function automatic void pend_push(input int d, input in_t e);
    if (d == 0) pend0.push_back(e);
    else pend1.push_back(e);
  endfunction
  function automatic exp_t sb_pop(input int d);
    if (d == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction
  function automatic void sb_push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popcnt(input logic [38:0] v);
    int c;
    c = 0;
    for (int i = 0; i <= 38; i++) if (v[i]) c++;
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    in_t  h;
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      if (pend_size(d) > 0 && ($urandom_range(99) < vprob[d])) begin
        h           = pend_head(d);
        in_valid[d] = 1'b1;
        data[d]     = h.data;
        mask[d]     = h.mask;
      end
      out_ready[d] = ($urandom_range(99) < rprob[d]);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (in_valid[d] && in_ready[d]) begin
        h      = pend_pop(d);
        e.cw   = h.fixed ? h.fcw : model(h.data, h.mask, (d == 0));
        e.inj  = |h.mask;
        e.data = h.data;
        e.mask = h.mask;
        sb_push(d, e);
        acc_cnt[d]++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    int busy;
    n    = 0;
    busy = 1;
    while (busy != 0 && n < budget) begin
      step();
      n++;
      busy = pend0.size() + pend1.size() + sb0.size() + sb1.size();
    end
    chk("drain_timeout", busy, 0);
  endtask

  function automatic void push_word(input int d, input logic [31:0] dv, input logic [38:0] mv);
    in_t p;
    p.data  = dv;
    p.mask  = mv;
    p.fixed = 1'b0;
    p.fcw   = '0;
    pend_push(d, p);
  endfunction

  function automatic void push_fixed(input int d, input logic [31:0] dv, input logic [38:0] cwv);
    in_t p;
    p.data  = dv;
    p.mask  = '0;
    p.fixed = 1'b1;
    p.fcw   = cwv;
    pend_push(d, p);
  endfunction

  function automatic logic [38:0] rand_mask();
    int          r;
    int          b0;
    int          b1;
    logic [38:0] m;
    m = '0;
    r = $urandom_range(99);
    if (r >= 80) begin
      b0    = $urandom_range(38);
      m[b0] = 1'b1;
      if (r >= 90) begin
        b1 = (b0 + 1 + $urandom_range(37)) % 39;
        m[b1] = 1'b1;
      end
    end
    return m;
  endfunction

  // ---------------- monitor ----------------
  task automatic mon_one(input int d);
    exp_t        e;
    logic [31:0] q;
    bit          sbe;
    bit          dbe;
    int          pc;
    chk($sformatf("word_cnt[%0d]", d), wcnt[d], cnt_model[d]);
    if (held[d]) begin
      chk($sformatf("stall_valid[%0d]", d), out_valid[d], 1'b1);
      chk($sformatf("stall_cw[%0d]", d), cw[d], held_cw[d]);
      chk($sformatf("stall_inj[%0d]", d), inj[d], held_inj[d]);
    end
    if (out_valid[d] && out_ready[d]) begin
      held[d] = 1'b0;
      n_xfer[d]++;
      cnt_model[d] = cnt_model[d] + 32'd1;
      if (sb_size(d) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out[%0d]: actual cw %0h required no word", d, cw[d]);
      end else begin
        e = sb_pop(d);
        chk($sformatf("cw[%0d]", d), cw[d], e.cw);
        chk($sformatf("inj[%0d]", d), inj[d], e.inj);
        pc = popcnt(e.mask);
        decode(cw[d], (d == 0), q, sbe, dbe);
        if (pc == 0) begin
          chk($sformatf("dec_clean_flags[%0d]", d), {sbe, dbe}, 2'b00);
          chk($sformatf("dec_clean_data[%0d]", d), q, e.data);
        end else if (pc == 1) begin
          chk($sformatf("dec_sb_flags[%0d]", d), {sbe, dbe}, 2'b10);
          chk($sformatf("dec_sb_data[%0d]", d), q, e.data);
        end else if (pc == 2) begin
          chk($sformatf("dec_db_flags[%0d]", d), {sbe, dbe}, 2'b01);
        end
      end
    end else if (out_valid[d]) begin
      held[d]     = 1'b1;
      held_cw[d]  = cw[d];
      held_inj[d] = inj[d];
    end else begin
      held[d] = 1'b0;
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      for (int d = 0; d < 2; d++) mon_one(d);
    end
  end

  function automatic void clear_state();
    pend0.delete(); pend1.delete(); sb0.delete(); sb1.delete();
    for (int d = 0; d < 2; d++) begin
      cnt_model[d] = '0;
      held[d]      = 1'b0;
      acc_cnt[d]   = 0;
    end
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int          base_x;
    logic [31:0] base_c;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      data[d]      = '0;
      mask[d]      = '0;
      n_xfer[d]    = 0;
      vprob[d]     = 100;
      rprob[d]     = 100;
    end
    clear_state();

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), out_valid[d], 1'b0);
      chk($sformatf("rst_cw[%0d]", d), cw[d], 39'h0);
      chk($sformatf("rst_inj[%0d]", d), inj[d], 1'b0);
      chk($sformatf("rst_word_cnt[%0d]", d), wcnt[d], 32'h0);
      chk($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors and latency
    push_fixed(0, 32'h0, 39'h00_0000_0000);
    push_fixed(1, 32'h0, 39'h00_0000_0000);
    push_fixed(0, 32'h1, 39'h00_0000_000F);
    push_fixed(1, 32'h1, 39'h40_0000_0007);
    step();
    step();
    chk("lat1_valid_after_1", out_valid[0], 1'b1);
    chk("lat2_valid_after_1", out_valid[1], 1'b0);
    step();
    chk("lat2_valid_after_2", out_valid[1], 1'b1);
    chk("word_cnt_first", wcnt[0], 32'd1);
    drain(50);

    // Fault-injection masks
    for (int d = 0; d < 2; d++) begin
      push_word(d, $urandom, 39'h1 << 5);
      push_word(d, $urandom, (39'h1 << 5) | (39'h1 << 9));
    end
    drain(50);

    // Backpressure
    for (int d = 0; d < 2; d++) begin
      rprob[d]   = 0;
      acc_cnt[d] = 0;
      for (int i = 0; i < 8; i++) push_word(d, $urandom, '0);
    end
    repeat (6) step();
    chk("bp_accepts_lat1", acc_cnt[0], 1);
    chk("bp_accepts_lat2", acc_cnt[1], 2);
    chk("bp_in_ready_lat2", in_ready[1], 1'b0);
    base_x = n_xfer[1];
    base_c = wcnt[1];
    rprob[0] = 100;
    rprob[1] = 100;
    repeat (9) step();
    chk("bp_back_to_back", n_xfer[1] - base_x, 8);
    chk("bp_word_cnt", wcnt[1], base_c + 32'd8);
    drain(50);

    // Randomized handshakes and data
    for (int d = 0; d < 2; d++) begin
      vprob[d] = 70;
      rprob[d] = 60;
      for (int i = 0; i < 5000; i++) push_word(d, $urandom, rand_mask());
    end
    drain(30000);

    // Reset with words in flight
    for (int d = 0; d < 2; d++) begin
      vprob[d] = 100;
      rprob[d] = 0;
      push_word(d, $urandom, '0);
      push_word(d, $urandom, '0);
    end
    repeat (4) step();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    clear_state();
    @(negedge clk);
    #1;
    chk("midrst_out_valid_b", out_valid[1], 1'b0);
    chk("midrst_word_cnt_b", wcnt[1], 32'h0);
    chk("midrst_out_valid_a", out_valid[0], 1'b0);
    chk("midrst_in_ready_b", in_ready[1], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rprob[0] = 100;
    rprob[1] = 100;
    repeat (4) step();

    // Counter wrap
    @(negedge clk);
    force dut_a.word_cnt_q = 32'hFFFF_FFFF;
    cnt_model[0] = 32'hFFFF_FFFF;
    #1;
    release dut_a.word_cnt_q;
    push_word(0, $urandom, '0);
    drain(20);
    step();
    chk("word_cnt_wrap", wcnt[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ecc_enc_stream.md
Name: ecc_enc_stream

Overview:
- Streaming SECDED Hamming encoder. It is the transmit-side counterpart of the project's SECDED decoder and produces code words in exactly the layout that decoder consumes.
- Accepts K-bit information words over a valid/ready handshake and emits (n+1)-bit code words after a configurable number of pipeline stages.
- Supports per-word fault injection for the fault-tolerance lab flow.
- Sits in front of ECC-protected storage or links.

Parameters:
- K, 32, information bit vector size.
- LATENCY, 1, 1: registered output stage only; 2: registered input stage plus output stage. Any other value is an elaboration error.
- P0_LSB, 1, 1: overall parity p0 at code word bit 0; 0: p0 at bit n.
- m, calculate_m(K), smallest m with 2**m >= m+K+1 (6 for K=32). Derived, never overridden.
- n, m+K, code word index range 1..n (38 for K=32). Derived, never overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  encoder can accept a word
- data_i  in  K  information bits
- inj_mask_i  in  n+1  fault-injection mask in output bit order, sampled with data_i
- out_valid_o  out  1  code word valid
- out_ready_i  in  1  sink accepts the code word
- cw_o  out  n+1  encoded code word
- inj_o  out  1  |mask of the word currently on cw_o
- word_cnt_o  out  32  count of completed output transfers, wraps at 2**32

Behaviour:
- Reset is synchronous and active-high, on rst_i at the clk_i edge. While rst_i is high:
  - All stages are emptied.
  - out_valid_o=0, cw_o=0, inj_o=0, word_cnt_o=0.
  - in_ready_o=0.
- A reset mid-operation drops in-flight words without emitting them.
- Encoding:
  - Internal cw[n:0]. Data bits go to the non-power-of-2 indices 1..n in ascending order: data_i[0] to index 3, data_i[1] to index 5, and so on.
  - Parity bit p_j (j=1..m) goes to index 2**(j-1) and equals the XOR of all data positions whose index has bit j-1 set.
  - cw[0] = XOR of cw[n:1], so the whole word has even parity.
- Output ordering:
  - P0_LSB=1: cw_o = cw.
  - P0_LSB=0: cw_o = {cw[0], cw[n:1]}.
  - The stored mask is then XORed into cw_o.
- Handshakes:
  - A transfer occurs on any cycle where valid and ready are both high.
  - out_valid_o, cw_o and inj_o stay stable while out_valid_o=1 and out_ready_i=0.
- Stage occupancy:
  - Each stage has a full flag.
  - A stage loads when upstream transfers and it is empty, or when it is draining in the same cycle.
  - in_ready_o = ~rst_i & (~first_stage_full | first_stage_drains_this_cycle). in_ready_o may depend combinationally on out_ready_i.
- Latency and throughput:
  - LATENCY=1: an accepted word appears on out_valid_o in the next cycle.
  - LATENCY=2: it appears two cycles later.
  - Sustained throughput is 1 word/cycle whenever out_ready_i=1.
- Backpressure: with out_ready_i=0 the pipeline fills. in_ready_o falls after LATENCY words are held. No word is lost or duplicated.
- Simultaneous events:
  - Drain plus accept in the same cycle keeps the stage full with the new word.
  - The counter increments on every output transfer; 0xFFFFFFFF wraps to 0.
- The encoding logic is combinational between stages. With LATENCY=2 the encoding is computed from the input stage register.

Decomposition:
- Shared package ecc_pkg holds:
  - calculate_m.
  - is_power_of_2.
  - Data-position mapping helpers, reused by the decoder.
- One natural sub-module: ecc_enc_core. It is purely combinational, maps K data bits to cw[n:0] before P0 placement, and is reusable by other memory wrappers.

Test Plan:
- K=32, P0_LSB=1, LATENCY=1, data_i=0x00000000, mask 0 -> cw_o=39'h00_0000_0000 one cycle later, inj_o=0, word_cnt_o=1 after transfer.
- data_i=0x00000001, P0_LSB=1 -> cw_o=39'h00_0000_000F. With P0_LSB=0 -> cw_o=39'h40_0000_0007.
- Round trip: 10k random words through the DUT into the SECDED decoder -> q_o equals data_i, sb_err_o=0, db_err_o=0. A one-hot mask at bit 5 -> decoder sb_err_o=1 and corrected q_o; a two-hot mask at bits 5 and 9 -> db_err_o=1; inj_o=1 in both cases.
- LATENCY=2, stream 8 words with out_ready_i held 0 -> in_ready_o low after 2 accepts. Release -> 8 words in order, back-to-back, word_cnt_o=8.
- Random in_valid_i/out_ready_i toggling for 1k cycles -> scoreboard order and data match, and cw_o stays stable during stalls.
- Assert rst_i with 2 words in flight -> out_valid_o=0 and word_cnt_o=0 next cycle. Preload the counter via force to 0xFFFFFFFF, transfer one word -> word_cnt_o wraps to 0.
